// File: rtl/ggt_arbiter.sv
// Round-robin front end that shares one gcd core between N_REQ requesters.
// Zero operands are answered locally; a silent core is cut off after TIMEOUT wait cycles.
module ggt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*W-1:0] zahl1_i,
    input  logic [N_REQ*W-1:0] zahl2_i,
    output logic [N_REQ-1:0]   gnt_o,
    output logic [N_REQ-1:0]   done_o,
    output logic [W-1:0]       ergebnis_o,
    output logic               err_o,
    output logic               busy_o,
    output logic               core_start_o,
    output logic [W-1:0]       core_zahl1_o,
    output logic [W-1:0]       core_zahl2_o,
    input  logic               core_valid_i,
    input  logic [W-1:0]       core_ergebnis_i,
    output logic               core_rst_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [W-1:0]  op1_reg, op1_next;
    logic [W-1:0]  op2_reg, op2_next;
    logic [W-1:0]  res_reg, res_next;
    logic          err_reg, err_next;
    logic          byp_reg, byp_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [W-1:0]  op1_arr [N_REQ];
    logic [W-1:0]  op2_arr [N_REQ];
    logic [IW-1:0] sel;
    logic          found;
    logic          core_rst_pulse;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign op1_arr[gi] = zahl1_i[gi*W +: W];
        assign op2_arr[gi] = zahl2_i[gi*W +: W];
    end

    // First active request at or above ptr, wrapping around.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        sel      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = int'(ptr_reg) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IW'(cand);
            if (!found && req_i[cand_idx]) begin
                found = 1'b1;
                sel   = cand_idx;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        idx_next       = idx_reg;
        op1_next       = op1_reg;
        op2_next       = op2_reg;
        res_next       = res_reg;
        err_next       = err_reg;
        byp_next       = byp_reg;
        cnt_next       = cnt_reg;
        gnt_o          = '0;
        done_o         = '0;
        ergebnis_o     = '0;
        err_o          = 1'b0;
        core_start_o   = 1'b0;
        core_rst_pulse = 1'b0;
        busy_o         = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (found) begin
                    idx_next = sel;
                    op1_next = op1_arr[sel];
                    op2_next = op2_arr[sel];
                    ptr_next = (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
                    err_next = 1'b0;
                    if (op1_arr[sel] == '0 || op2_arr[sel] == '0) begin
                        // gcd(x,0) = x, so the OR of the operands is the answer
                        byp_next   = 1'b1;
                        res_next   = op1_arr[sel] | op2_arr[sel];
                        state_next = RESP;
                    end else begin
                        byp_next   = 1'b0;
                        state_next = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                core_start_o     = 1'b1;
                gnt_o[idx_reg]   = 1'b1;
                cnt_next         = '0;
                state_next       = WAIT;
            end
            WAIT: begin
                // A valid result wins over a timeout landing on the same edge.
                if (core_valid_i) begin
                    res_next   = core_ergebnis_i;
                    err_next   = 1'b0;
                    state_next = RESP;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    res_next   = '0;
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                done_o[idx_reg] = 1'b1;
                gnt_o[idx_reg]  = byp_reg;
                ergebnis_o      = res_reg;
                err_o           = err_reg;
                core_rst_pulse  = err_reg;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign core_zahl1_o = op1_reg;
    assign core_zahl2_o = op2_reg;
    assign core_rst_o   = ~rst_ni | core_rst_pulse;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
            op1_reg   <= '0;
            op2_reg   <= '0;
            res_reg   <= '0;
            err_reg   <= 1'b0;
            byp_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
            op1_reg   <= op1_next;
            op2_reg   <= op2_next;
            res_reg   <= res_next;
            err_reg   <= err_next;
            byp_reg   <= byp_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_ggt_arbiter.sv
// Bench for ggt_arbiter: a behavioural gcd core plus a transaction-level model
// (round-robin pointer, gcd/bypass/timeout outcome, expected latency).
module tb_ggt_arbiter;

    localparam int N = 4;
    localparam int W = 16;
    localparam int T = 32;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [W-1:0]   op1 [N];
    logic [W-1:0]   op2 [N];
    logic [N*W-1:0] zahl1_i, zahl2_i;
    logic [N-1:0]   gnt_o, done_o;
    logic [W-1:0]   ergebnis_o, core_zahl1_o, core_zahl2_o;
    logic [W-1:0]   core_ergebnis_i = '0;
    logic           err_o, busy_o, core_start_o, core_rst_o;
    logic           core_valid_i = 1'b0;

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;

    int          core_delay = 1;
    int          core_cnt = 0;
    bit          core_active = 1'b0;
    logic [W-1:0] core_res = '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign zahl1_i[gi*W +: W] = op1[gi];
        assign zahl2_i[gi*W +: W] = op2[gi];
    end

    ggt_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(T)) dut (
        .clk(clk), .rst_ni(rst_ni), .req_i(req_i),
        .zahl1_i(zahl1_i), .zahl2_i(zahl2_i),
        .gnt_o(gnt_o), .done_o(done_o), .ergebnis_o(ergebnis_o),
        .err_o(err_o), .busy_o(busy_o), .core_start_o(core_start_o),
        .core_zahl1_o(core_zahl1_o), .core_zahl2_o(core_zahl2_o),
        .core_valid_i(core_valid_i), .core_ergebnis_i(core_ergebnis_i),
        .core_rst_o(core_rst_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, r;
        x = a;
        y = b;
        while (y != 0) begin
            r = x % y;
            x = y;
            y = r;
        end
        return x;
    endfunction

    // Core: answers core_delay cycles after start (0 = never); noise on valid while idle.
    always @(negedge clk) begin
        if (!rst_ni || core_rst_o) begin
            core_active  <= 1'b0;
            core_valid_i <= 1'b0;
        end else if (core_start_o) begin
            core_active  <= (core_delay != 0);
            core_cnt     <= core_delay;
            core_res     <= gcd(core_zahl1_o, core_zahl2_o);
            core_valid_i <= 1'b0;
        end else if (core_active) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_valid_i    <= 1'b1;
                core_ergebnis_i <= core_res;
                core_active     <= 1'b0;
            end else begin
                core_valid_i <= 1'b0;
            end
        end else if (!busy_o) begin
            core_valid_i    <= 1'($urandom_range(0, 1));
            core_ergebnis_i <= W'($urandom);
        end else begin
            core_valid_i <= 1'b0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_gnt"},   32'(gnt_o), 32'd0);
        check_val({tag, "_done"},  32'(done_o), 32'd0);
        check_val({tag, "_err"},   32'(err_o), 32'd0);
        check_val({tag, "_busy"},  32'(busy_o), 32'd0);
        check_val({tag, "_start"}, 32'(core_start_o), 32'd0);
        check_val({tag, "_res"},   32'(ergebnis_o), 32'd0);
        check_val({tag, "_z1"},    32'(core_zahl1_o), 32'd0);
        check_val({tag, "_z2"},    32'(core_zahl2_o), 32'd0);
        check_val({tag, "_crst"},  32'(core_rst_o), 32'd1);
    endtask

    function automatic logic [W-1:0] rand_op(input int g);
        if ($urandom_range(0, 7) == 0) return '0;
        return W'(g * int'($urandom_range(1, 300)));
    endfunction

    task automatic randomize_inputs();
        int g;
        req_i = N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) begin
            g = int'($urandom_range(1, 200));
            op1[i] = rand_op(g);
            op2[i] = rand_op(g);
        end
    endtask

    // Called at a negedge with the DUT idle and a non-zero req_i already driven.
    task automatic run_txn(input int d, input bit scramble);
        int           w, c, tdone;
        logic [N-1:0] oh;
        logic [W-1:0] a, b, er;
        logic [N-1:0] req_seen;
        bit           byp, tmo;
        w = -1;
        for (int o = 0; o < N; o++) begin
            c = (ptr_m + o) % N;
            if (w < 0 && req_i[c]) w = c;
        end
        req_seen = req_i;
        ptr_m = (w + 1) % N;
        oh    = N'(1) << w;
        a     = op1[w];
        b     = op2[w];
        byp   = (a == 0) || (b == 0);
        tmo   = !byp && !(d != 0 && d <= T);
        tdone = byp ? 0 : (tmo ? T + 1 : d + 1);
        er    = byp ? (a | b) : (tmo ? '0 : gcd(a, b));
        core_delay = d;
        for (int t = 0; t <= tdone; t++) begin
            @(negedge clk);
            check_val("gnt",   32'(gnt_o),  32'((t == 0) ? oh : {N{1'b0}}));
            check_val("done",  32'(done_o), 32'((t == tdone) ? oh : {N{1'b0}}));
            check_val("start", 32'(core_start_o), 32'(!byp && t == 0));
            check_val("busy",  32'(busy_o), 32'd1);
            check_val("err",   32'(err_o), 32'(tmo && t == tdone));
            check_val("crst",  32'(core_rst_o), 32'(tmo && t == tdone));
            if (t == tdone) check_val("result", 32'(ergebnis_o), 32'(er));
            if (!byp) begin
                check_val("core_z1", 32'(core_zahl1_o), 32'(a));
                check_val("core_z2", 32'(core_zahl2_o), 32'(b));
            end
            if (scramble) randomize_inputs();
        end
        @(negedge clk);
        check_val("idle_busy", 32'(busy_o), 32'd0);
        check_val("idle_done", 32'(done_o), 32'd0);
        check_val("idle_gnt",  32'(gnt_o), 32'd0);
        $display("txn req=%b win=%0d a=%0d b=%0d d=%0d res=%0d err=%0b lat=%0d",
                 req_seen, w, a, b, d, er, tmo, tdone);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            op1[i] = W'(6 * (i + 1));
            op2[i] = W'(4 * (i + 2));
        end
        #3;
        check_reset_outs("por");
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // Fairness with all four requesting and immediate core answers
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) run_txn(1, 1'b0);

        // Single request through the core
        req_i  = 4'b0001;
        op1[0] = 16'd24255;
        op2[0] = 16'd12540;
        run_txn(20, 1'b0);

        // Zero bypass
        req_i  = 4'b0100;
        op1[2] = 16'd0;
        op2[2] = 16'd42;
        run_txn(5, 1'b0);
        op2[2] = 16'd0;
        run_txn(5, 1'b0);

        // Stuck core, then a normal request, then valid coinciding with timeout
        req_i  = 4'b0010;
        op1[1] = 16'd91;
        op2[1] = 16'd35;
        run_txn(0, 1'b0);
        run_txn(3, 1'b0);
        run_txn(T, 1'b0);

        // Reset while waiting on the core
        req_i      = 4'b0100;
        op1[2]     = 16'd30;
        op2[2]     = 16'd12;
        core_delay = 0;
        @(negedge clk);
        check_val("rst_pre_gnt", 32'(gnt_o), 32'(4'b0100));
        repeat (3) @(negedge clk);
        check_val("rst_pre_busy", 32'(busy_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1 check_reset_outs("midrst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("rst_no_done", 32'(done_o), 32'd0);
            check_val("rst_busy", 32'(busy_o), 32'd0);
        end
        rst_ni = 1'b1;
        ptr_m  = 0;
        req_i  = 4'b1111;
        run_txn(2, 1'b0);

        // Randomised traffic with input churn while busy
        for (int k = 0; k < 60; k++) begin
            int d;
            randomize_inputs();
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, T + 2));
            run_txn(d, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
